// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller: owns the 10 ms prescaler, the BCD mm:ss.cc
// counter chain and the IDLE/RUN/PAUSE/FULL sequencing driven by debounced key pulses.
module stopwatch_ctrl #(
  parameter int CLK_DIV = 500000,
  parameter int DIV_W   = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ps_en,
  input  logic       key_rst_en,
  output logic [1:0] state,
  output logic       run,
  output logic       tick,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_FULL  = 2'b11
  } state_e;

  // Digit order, LSB first: cs ones, cs tens, sec ones, sec tens, min ones, min tens.
  localparam logic [5:0][3:0] DIG_MAX  = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [23:0]     FULL_VAL = 24'h595999;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0][3:0]    cnt_q, cnt_d, cnt_inc;
  logic               tick_q, run_q;
  logic               wrap, at_full, inc_cy, clr;

  assign wrap = (state_q == S_RUN) && (div_q == DIV_LAST);

  // Ripple BCD increment: each digit rolls at its own limit and carries upward.
  always_comb begin
    cnt_inc = cnt_q;
    inc_cy  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (inc_cy) begin
        if (cnt_q[i] == DIG_MAX[i]) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          inc_cy     = 1'b0;
        end
      end
    end
  end

  assign at_full = (cnt_inc == FULL_VAL);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (key_ps_en) state_d = S_RUN;
      end
      S_RUN: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) cnt_d = cnt_inc;
        // Reaching 59:59.99 takes priority over a pause on the same edge.
        if (wrap && at_full) state_d = S_FULL;
        else if (key_ps_en)  state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (key_rst_en)     clr = 1'b1;
        else if (key_ps_en) state_d = S_RUN;
      end
      S_FULL: begin
        div_d = '0;
        if (key_rst_en) clr = 1'b1;
      end
    endcase
    if (clr) begin
      state_d = S_IDLE;
      div_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= wrap;
      run_q   <= (state_d == S_RUN);
    end
  end

  assign state   = state_q;
  assign run     = run_q;
  assign tick    = tick_q;
  assign cs_bcd  = {cnt_q[1], cnt_q[0]};
  assign sec_bcd = {cnt_q[3], cnt_q[2]};
  assign min_bcd = {cnt_q[5], cnt_q[4]};

endmodule
